edusoc_board_io: RTL and testbench



---
 rtl/edusoc_board_io_if.sv | 25 ++
 rtl/edusoc_board_io.sv | 113 +++++++++++
 tb/tb_edusoc_board_io.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/edusoc_board_io_if.sv
// SoC-facing bundle of the board I/O bridge: GPIO words, PWM channels and
// the interrupt pending/mask/clear signals. The master side is the SoC, the
// slave side is edusoc_board_io.
interface edusoc_board_io_if #(
  parameter int CH_COUNT  = 8,
  parameter int RGB_COUNT = 2
);
  logic [31:0]          gpio_out;
  logic [3*RGB_COUNT-1:0] pwm;
  logic [31:0]          gpio_in;
  logic [CH_COUNT-1:0]  irq_mask;
  logic [CH_COUNT-1:0]  irq_clear;
  logic [CH_COUNT-1:0]  irq_pending;
  logic                 irq;

  modport master (
    output gpio_out, pwm, irq_mask, irq_clear,
    input  gpio_in, irq_pending, irq
  );

  modport slave (
    input  gpio_out, pwm, irq_mask, irq_clear,
    output gpio_in, irq_pending, irq
  );
endinterface

// File: rtl/edusoc_board_io.sv
// Board I/O bridge between Arty-7 style pins and the EduSoC GPIO/PWM/IRQ signals.
// Buttons and switches are synchronised and debounced, mapped into gpio_in[16+],
// and their edges latch sticky pending flags that form a level interrupt.
// Optional feature macro: EDUSOC_BOARD_IO_RELEASE_EVENT_EN -- when defined,
// button releases also raise pending flags (switches always flag both edges).
module edusoc_board_io #(
  parameter int BUTTON_COUNT    = 4,
  parameter int SWITCH_COUNT    = 4,
  parameter int LED_COUNT       = 4,
  parameter int RGB_COUNT       = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic                      clk,
  input  logic                      resn,
  input  logic [BUTTON_COUNT-1:0]   board_button,
  input  logic [SWITCH_COUNT-1:0]   board_switch,
  output logic [LED_COUNT-1:0]      board_led,
  output logic [3*RGB_COUNT-1:0]    board_led_rgb,
  edusoc_board_io_if.slave          soc
);

  localparam int CH    = BUTTON_COUNT + SWITCH_COUNT;
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Channels whose 1->0 debounced transition raises an event.
`ifdef EDUSOC_BOARD_IO_RELEASE_EVENT_EN
  localparam logic [CH-1:0] FALL_SEL = {CH{1'b1}};
`else
  localparam logic [CH-1:0] FALL_SEL = {{SWITCH_COUNT{1'b1}}, {BUTTON_COUNT{1'b0}}};
`endif

  logic [CH-1:0]                  raw;
  logic [SYNC_STAGES-1:0][CH-1:0] sync_q, sync_d;
  logic [CH-1:0]                  stable_q, stable_d;
  logic [CH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic [CH-1:0]                  pending_q, pending_d;
  logic [CH-1:0]                  synced;
  logic [CH-1:0]                  event_w;
  logic [31:0]                    gpio_in_w;
  logic [3*RGB_COUNT-1:0]         rgb_w;
  logic                           unused_gpio;

  assign raw    = {board_switch, board_button};
  assign synced = sync_q[SYNC_STAGES-1];

  // Shift raw pins through the synchroniser chain.
  always_comb begin
    sync_d[0] = raw;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  // Debounce: a differing synced level must persist DEBOUNCE_CYCLES edges to be accepted.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    for (int i = 0; i < CH; i++) begin
      if (synced[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = synced[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Edge events latch into sticky flags; a coincident clear loses to a new event.
  always_comb begin
    event_w   = (stable_d & ~stable_q) | (~stable_d & stable_q & FALL_SEL);
    pending_d = (pending_q & ~soc.irq_clear) | event_w;
  end

  // All input-path state, cleared by the synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resn) begin
      sync_q    <= '0;
      stable_q  <= '0;
      cnt_q     <= '0;
      pending_q <= '0;
    end else begin
      sync_q    <= sync_d;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

  // Debounced inputs occupy the upper half of the GPIO input word.
  always_comb begin
    gpio_in_w          = '0;
    gpio_in_w[16 +: CH] = stable_q;
  end

  // Each RGB LED ORs its PWM triple with a GPIO nibble starting at bit 8.
  always_comb begin
    rgb_w = '0;
    for (int k = 0; k < RGB_COUNT; k++) begin
      rgb_w[3*k +: 3] = soc.pwm[3*k +: 3] | soc.gpio_out[8+4*k +: 3];
    end
  end

  assign soc.gpio_in     = gpio_in_w;
  assign soc.irq_pending = pending_q;
  assign soc.irq         = |(pending_q & soc.irq_mask);
  assign board_led       = soc.gpio_out[LED_COUNT-1:0];
  assign board_led_rgb   = rgb_w;
  assign unused_gpio     = ^soc.gpio_out;

endmodule

// File: tb/tb_edusoc_board_io.sv
// Directed self-checking bench for edusoc_board_io with DEBOUNCE_CYCLES=4.
module tb_edusoc_board_io;

  logic       clk = 1'b0;
  logic       resn;
  logic [3:0] board_button;
  logic [3:0] board_switch;
  logic [3:0] board_led;
  logic [5:0] board_led_rgb;
  int         total_checks = 0;
  int         passed_checks = 0;

  edusoc_board_io_if #(.CH_COUNT(8), .RGB_COUNT(2)) soc_bus ();

  edusoc_board_io #(
    .BUTTON_COUNT(4), .SWITCH_COUNT(4), .LED_COUNT(4), .RGB_COUNT(2),
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk), .resn(resn),
    .board_button(board_button), .board_switch(board_switch),
    .board_led(board_led), .board_led_rgb(board_led_rgb),
    .soc(soc_bus)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic stepCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] btn, input logic [3:0] sw);
    board_button = btn;
    board_switch = sw;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_checks++;
    assert (obs === exp) passed_checks++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    logic [7:0] rel_exp;
`ifdef EDUSOC_BOARD_IO_RELEASE_EVENT_EN
    rel_exp = 8'h01;
`else
    rel_exp = 8'h00;
`endif
    soc_bus.gpio_out  = '0;
    soc_bus.pwm       = '0;
    soc_bus.irq_mask  = '0;
    soc_bus.irq_clear = '0;

    // Reset with all pins high
    resn = 1'b0;
    applyStimulus(4'hF, 4'hF);
    stepCycles(3);
    checkOutput("rst_gpio_in", soc_bus.gpio_in, 32'h0);
    checkOutput("rst_pending", {24'h0, soc_bus.irq_pending}, 32'h0);
    checkOutput("rst_irq", {31'h0, soc_bus.irq}, 32'h0);

    // Held-high pins re-debounce after reset and raise events
    resn = 1'b1;
    stepCycles(5);
    checkOutput("post_rst_early", soc_bus.gpio_in, 32'h0);
    stepCycles(1);
    checkOutput("post_rst_gpio", soc_bus.gpio_in, 32'h00FF_0000);
    checkOutput("post_rst_pending", {24'h0, soc_bus.irq_pending}, 32'h0000_00FF);

    // Return to a quiet state
    applyStimulus(4'h0, 4'h0);
    resn = 1'b0;
    stepCycles(2);
    resn = 1'b1;
    stepCycles(2);
    checkOutput("quiet_gpio", soc_bus.gpio_in, 32'h0);
    checkOutput("quiet_pending", {24'h0, soc_bus.irq_pending}, 32'h0);

    // Button 0 press: visible exactly 6 edges later
    soc_bus.irq_mask = 8'h01;
    applyStimulus(4'b0001, 4'h0);
    stepCycles(5);
    checkOutput("press_early_gpio", soc_bus.gpio_in, 32'h0);
    checkOutput("press_early_irq", {31'h0, soc_bus.irq}, 32'h0);
    stepCycles(1);
    checkOutput("press_gpio", soc_bus.gpio_in, 32'h0001_0000);
    checkOutput("press_pending", {24'h0, soc_bus.irq_pending}, 32'h01);
    checkOutput("press_irq", {31'h0, soc_bus.irq}, 32'h1);

    // Button 1 glitch of 3 synced cycles is rejected
    applyStimulus(4'b0011, 4'h0);
    stepCycles(3);
    applyStimulus(4'b0001, 4'h0);
    stepCycles(10);
    checkOutput("glitch_gpio", soc_bus.gpio_in, 32'h0001_0000);
    checkOutput("glitch_pending", {24'h0, soc_bus.irq_pending}, 32'h01);

    // Mask gates irq only
    soc_bus.irq_mask = 8'h02;
    #1;
    checkOutput("mask_irq", {31'h0, soc_bus.irq}, 32'h0);
    checkOutput("mask_pending", {24'h0, soc_bus.irq_pending}, 32'h01);
    soc_bus.irq_mask = 8'h01;

    // Output merging
    soc_bus.gpio_out = 32'h0000_0505;
    soc_bus.pwm      = 6'b000_010;
    #1;
    checkOutput("led_a", {28'h0, board_led}, 32'h5);
    checkOutput("rgb_a", {26'h0, board_led_rgb}, 32'b000_111);
    soc_bus.gpio_out = 32'h0000_7A3C;
    soc_bus.pwm      = 6'b101_000;
    #1;
    checkOutput("led_b", {28'h0, board_led}, 32'hC);
    checkOutput("rgb_b", {26'h0, board_led_rgb}, 32'b111_010);

    // Clear button 0 in the same cycle switch 0 debounces
    applyStimulus(4'b0001, 4'b0001);
    stepCycles(5);
    soc_bus.irq_clear = 8'h01;
    stepCycles(1);
    soc_bus.irq_clear = 8'h00;
    checkOutput("sw_rise_pending", {24'h0, soc_bus.irq_pending}, 32'h10);
    checkOutput("sw_rise_gpio", soc_bus.gpio_in, 32'h0011_0000);

    // Clear of switch 0 coinciding with its falling event: set wins
    applyStimulus(4'b0001, 4'b0000);
    stepCycles(5);
    soc_bus.irq_clear = 8'h10;
    stepCycles(1);
    soc_bus.irq_clear = 8'h00;
    checkOutput("set_wins_pending", {24'h0, soc_bus.irq_pending}, 32'h10);
    checkOutput("sw_fall_gpio", soc_bus.gpio_in, 32'h0001_0000);

    // Plain clear, plus a clear on an idle channel
    soc_bus.irq_clear = 8'h30;
    stepCycles(1);
    soc_bus.irq_clear = 8'h00;
    checkOutput("clear_pending", {24'h0, soc_bus.irq_pending}, 32'h0);

    // Button 0 release
    applyStimulus(4'b0000, 4'b0000);
    stepCycles(5);
    checkOutput("release_early_gpio", soc_bus.gpio_in, 32'h0001_0000);
    stepCycles(1);
    checkOutput("release_gpio", soc_bus.gpio_in, 32'h0);
    checkOutput("release_pending", {24'h0, soc_bus.irq_pending}, {24'h0, rel_exp});
    checkOutput("release_irq", {31'h0, soc_bus.irq}, {31'h0, rel_exp[0]});
    soc_bus.irq_clear = 8'hFF;
    stepCycles(1);
    soc_bus.irq_clear = 8'h00;

    // Reset mid-debounce discards the partial count
    applyStimulus(4'b0100, 4'b0000);
    stepCycles(3);
    resn = 1'b0;
    stepCycles(1);
    resn = 1'b1;
    stepCycles(5);
    checkOutput("mid_rst_early", soc_bus.gpio_in, 32'h0);
    stepCycles(1);
    checkOutput("mid_rst_gpio", soc_bus.gpio_in, 32'h0004_0000);
    checkOutput("mid_rst_pending", {24'h0, soc_bus.irq_pending}, 32'h04);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
